// File: rtl/motor_pkg.sv
// Shared encodings for the wheel-motor ramp driver: direction codes from the
// direction FSM, driver states and the duty width.
package motor_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {
    IDLE_BASE  = 3'b000,
    FORWARDS   = 3'b001,
    IDLE_TABLE = 3'b010,
    BACKWARDS  = 3'b011,
    STOP       = 3'b100
  } direction_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD,
    ESTOP
  } drv_state_t;

endpackage

// File: rtl/pwm_gen.sv
// Free-running 8-bit PWM: a prescaler advances the counter, which is compared
// against the duty value.
module pwm_gen
  import motor_pkg::*;
#(
  parameter int PWM_PRESCALE = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty,
  input  logic              en,
  output logic              pwm
);

  localparam int PRE_W = $clog2(PWM_PRESCALE + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);

  logic [PRE_W-1:0]  pre_cnt;
  logic [DUTY_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      cnt     <= cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Compare of registered values only; duty = 0 yields a constant low.
  assign pwm = en && (cnt < duty);

endmodule

// File: rtl/motor_ramp_driver.sv
// Wheel-motor H-bridge driver with linear duty ramp, reversal dead time and
// emergency stop. Define MOTOR_BRAKE_EN to short-brake (fwd=rev=pwm=1) in ESTOP.
module motor_ramp_driver
  import motor_pkg::*;
#(
  parameter int PWM_PRESCALE     = 10,
  parameter int RAMP_STEP_CYCLES = 50000,
  parameter int DEADTIME_CYCLES  = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        direction,
  input  logic [DUTY_W-1:0] max_duty,
  output logic              motor_fwd,
  output logic              motor_rev,
  output logic              motor_pwm,
  output logic [DUTY_W-1:0] duty,
  output logic              busy
);

`ifdef MOTOR_BRAKE_EN
  localparam logic BRAKE = 1'b1;
`else
  localparam logic BRAKE = 1'b0;
`endif

  localparam int RAMP_W = $clog2(RAMP_STEP_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYCLES - 1);

  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    else                return cur;
  endfunction

  drv_state_t        state;
  direction_t        cur_dir;
  logic [RAMP_W-1:0] tick_cnt;
  logic [DEAD_W-1:0] dead_cnt;

  logic              req_stop, req_fwd, req_bwd, req_motion, same_dir;
  direction_t        req_dir;
  logic [DUTY_W-1:0] target;
  logic              pwm_raw;

  // Codes 100-111 all count as STOP.
  assign req_stop   = direction[2];
  assign req_fwd    = (direction == FORWARDS);
  assign req_bwd    = (direction == BACKWARDS);
  assign req_motion = req_fwd | req_bwd;
  assign req_dir    = req_bwd ? BACKWARDS : FORWARDS;
  assign same_dir   = req_motion && (req_dir == cur_dir);
  assign target     = same_dir ? max_duty : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_dir   <= FORWARDS;
      duty      <= '0;
      tick_cnt  <= '0;
      dead_cnt  <= '0;
      motor_fwd <= 1'b0;
      motor_rev <= 1'b0;
      busy      <= 1'b1 & 1'b0;
    end else if (req_stop) begin
      // Emergency halt wins from every state and skips the ramp entirely.
      state     <= ESTOP;
      duty      <= '0;
      motor_fwd <= BRAKE;
      motor_rev <= BRAKE;
      busy      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_motion) begin
            state     <= RUN;
            cur_dir   <= req_dir;
            tick_cnt  <= '0;
            motor_fwd <= req_fwd;
            motor_rev <= req_bwd;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (duty == '0 && !same_dir) begin
            // Legs only drop once the wheels are fully ramped down.
            motor_fwd <= 1'b0;
            motor_rev <= 1'b0;
            if (req_motion) begin
              state    <= DEAD;
              dead_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (tick_cnt == RAMP_LAST) begin
            tick_cnt <= '0;
            duty     <= step_toward(duty, target);
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            if (req_motion) begin
              state     <= RUN;
              cur_dir   <= req_dir;
              tick_cnt  <= '0;
              motor_fwd <= req_fwd;
              motor_rev <= req_bwd;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        ESTOP: begin
          state     <= IDLE;
          motor_fwd <= 1'b0;
          motor_rev <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pwm_gen #(
    .PWM_PRESCALE(PWM_PRESCALE)
  ) u_pwm (
    .clk  (clk),
    .reset(reset),
    .duty (duty),
    .en   (state == RUN),
    .pwm  (pwm_raw)
  );

  assign motor_pwm = (state == ESTOP) ? BRAKE : pwm_raw;

endmodule

// File: tb/tb_motor_ramp_driver.sv
// Directed bench for motor_ramp_driver with short ramp/dead-time parameters.
module tb_motor_ramp_driver;
  import motor_pkg::*;

`ifdef MOTOR_BRAKE_EN
  localparam logic BRK = 1'b1;
`else
  localparam logic BRK = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [2:0]        direction;
  logic [DUTY_W-1:0] max_duty;
  logic              motor_fwd, motor_rev, motor_pwm, busy;
  logic [DUTY_W-1:0] duty;

  int checks = 0;
  int errors = 0;

  motor_ramp_driver #(
    .PWM_PRESCALE    (1),
    .RAMP_STEP_CYCLES(4),
    .DEADTIME_CYCLES (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .direction(direction),
    .max_duty (max_duty),
    .motor_fwd(motor_fwd),
    .motor_rev(motor_rev),
    .motor_pwm(motor_pwm),
    .duty     (duty),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int both_hi, fwd_drop, rev_rise, duty_at_drop, dead_pwm, duty64, dead_busy, hi_cnt;

    reset = 1'b1; direction = 3'b000; max_duty = 8'd0;
    tick(3);
    check("rst_duty", duty, 0);
    check("rst_fwd", motor_fwd, 0);
    check("rst_rev", motor_rev, 0);
    check("rst_pwm", motor_pwm, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick(2);
    check("idle_base_busy", busy, 0);
    direction = 3'b010;
    tick(1);
    check("idle_table_busy", busy, 0);

    // Ramp up to 16 forwards
    max_duty = 8'd16; direction = 3'b001;
    tick(1);
    check("run_busy", busy, 1);
    check("run_fwd", motor_fwd, 1);
    check("run_rev", motor_rev, 0);
    check("run_duty0", duty, 0);
    tick(4);
    check("ramp_duty1", duty, 1);
    tick(59);
    check("ramp_duty15", duty, 15);
    tick(1);
    check("ramp_duty16", duty, 16);
    tick(8);
    check("ramp_hold16", duty, 16);

    // Ramp down to rest
    direction = 3'b010;
    tick(63);
    check("down_duty1", duty, 1);
    tick(1);
    check("down_duty0", duty, 0);
    check("down_fwd_held", motor_fwd, 1);
    tick(1);
    check("rest_busy", busy, 0);
    check("rest_fwd", motor_fwd, 0);
    check("rest_pwm", motor_pwm, 0);

    // Reversal forwards -> backwards
    direction = 3'b001;
    tick(65);
    check("rev_pre_duty16", duty, 16);
    direction = 3'b011;
    both_hi = 0; fwd_drop = 0; rev_rise = 0; duty_at_drop = -1;
    dead_pwm = 0; duty64 = -1; dead_busy = -1;
    for (int i = 1; i <= 89; i++) begin
      tick(1);
      if (motor_fwd && motor_rev) both_hi++;
      if (fwd_drop == 0 && !motor_fwd) begin
        fwd_drop = i;
        duty_at_drop = int'(duty);
      end
      if (rev_rise == 0 && motor_rev) rev_rise = i;
      if (i >= 65 && i < 85 && (motor_pwm || motor_fwd || motor_rev)) dead_pwm++;
      if (i == 64) duty64 = int'(duty);
      if (i == 75) dead_busy = int'(busy);
    end
    check("rev_both_high", both_hi, 0);
    check("rev_duty_at_64", duty64, 0);
    check("rev_fwd_drop_cycle", fwd_drop, 65);
    check("rev_duty_at_drop", duty_at_drop, 0);
    check("rev_dead_legs", dead_pwm, 0);
    check("rev_dead_busy", dead_busy, 1);
    check("rev_rise_cycle", rev_rise, 85);
    check("rev_duty_rising", duty, 1);
    check("rev_fwd_low", motor_fwd, 0);

    // Emergency stop mid-ramp at duty 7
    tick(24);
    check("estop_pre_duty7", duty, 7);
    direction = 3'b100;
    tick(1);
    check("estop_duty", duty, 0);
    check("estop_fwd", motor_fwd, BRK);
    check("estop_rev", motor_rev, BRK);
    check("estop_pwm", motor_pwm, BRK);
    check("estop_busy", busy, 1);
    tick(3);
    check("estop_hold_busy", busy, 1);
    direction = 3'b000;
    tick(1);
    check("estop_exit_busy", busy, 0);
    check("estop_exit_fwd", motor_fwd, 0);
    check("estop_exit_pwm", motor_pwm, 0);
    direction = 3'b111;
    tick(1);
    check("code7_busy", busy, 1);
    check("code7_rev", motor_rev, BRK);
    direction = 3'b000;
    tick(1);
    check("code7_exit_busy", busy, 0);

    // PWM duty cycle at 64, max_duty reduction, then reset mid-run
    max_duty = 8'd64; direction = 3'b001;
    tick(257);
    check("pwm_duty64", duty, 64);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (motor_pwm) hi_cnt++;
    end
    check("pwm_high_count", hi_cnt, 64);
    max_duty = 8'd60;
    tick(4);
    check("maxdown_duty63", duty, 63);
    tick(12);
    check("maxdown_duty60", duty, 60);
    tick(8);
    check("maxdown_hold60", duty, 60);
    reset = 1'b1;
    tick(1);
    check("midrst_duty", duty, 0);
    check("midrst_fwd", motor_fwd, 0);
    check("midrst_pwm", motor_pwm, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0; direction = 3'b000;
    tick(2);
    check("post_rst_busy", busy, 0);
    check("post_rst_duty", duty, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
